// File: rtl/result_writer_if.sv
// Handshake bundle between the edge-detector output stream, result_writer and the RAM write port.
// RESULT_WRITER_BYTE_MASK_EN adds the ram_byte_en lane mask.
interface result_writer_if;
    logic                 start;
    logic [31:0]          start_addr;
    logic                 pixel_valid;
    logic [7:0]           pixel_in;
    logic                 pixel_ready;
    logic                 ram_write;
    logic [31:0]          ram_out_addr;
    logic [3:0][7:0]      ram_wdata;
    logic                 ram_ack;
    logic                 busy;
    logic                 edge_write_done;
`ifdef RESULT_WRITER_BYTE_MASK_EN
    logic [3:0]           ram_byte_en;
`endif

    modport master (
`ifdef RESULT_WRITER_BYTE_MASK_EN
        input  ram_byte_en,
`endif
        output start, start_addr, pixel_valid, pixel_in, ram_ack,
        input  pixel_ready, ram_write, ram_out_addr, ram_wdata, busy, edge_write_done
    );

    modport slave (
`ifdef RESULT_WRITER_BYTE_MASK_EN
        output ram_byte_en,
`endif
        input  start, start_addr, pixel_valid, pixel_in, ram_ack,
        output pixel_ready, ram_write, ram_out_addr, ram_wdata, busy, edge_write_done
    );
endinterface

// File: rtl/result_writer.sv
// Packs the 8-bit edge pixel stream into 32-bit words and writes them to RAM from a base address.
// Optional macro RESULT_WRITER_BYTE_MASK_EN adds a per-lane byte enable for the partial last word.
//
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_COLLECT | accepting pixels into the pack register
//   S_WRITE   | holding a word on the RAM port until ram_ack
//   S_DONE    | one-cycle completion pulse
module result_writer #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic           clk,
    input  logic           n_rst,
    result_writer_if.slave bus
);
    localparam int            NPIX   = IMG_W * IMG_H;
    localparam int            CW     = $clog2(NPIX + 1);
    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [CW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [2:0]      lane_q, lane_d;
    logic [3:0][7:0] pack_q, pack_d;
    logic [CW-1:0]   pix_cnt_inc;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            pix_cnt_q <= '0;
            lane_q    <= '0;
            pack_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pix_cnt_q <= pix_cnt_d;
            lane_q    <= lane_d;
            pack_q    <= pack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pix_cnt_d   = pix_cnt_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        pix_cnt_inc = pix_cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d    = {bus.start_addr[31:2], 2'b00};
                    pix_cnt_d = '0;
                    lane_d    = '0;
                    pack_d    = '0;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.pixel_valid) begin
                    pack_d[lane_q[1:0]] = bus.pixel_in;
                    lane_d              = lane_q + 3'd1;
                    pix_cnt_d           = pix_cnt_inc;
                    // A short final word leaves early; its upper lanes are still zero from the last clear.
                    if (lane_q == 3'd3 || pix_cnt_inc == NPIX_C) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (bus.ram_ack) begin
                    addr_d  = addr_q + 32'd4;
                    lane_d  = '0;
                    pack_d  = '0;
                    state_d = (pix_cnt_q == NPIX_C) ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.pixel_ready     = (state_q == S_COLLECT);
    assign bus.ram_write       = (state_q == S_WRITE);
    assign bus.ram_out_addr    = addr_q;
    assign bus.ram_wdata       = pack_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.edge_write_done = (state_q == S_DONE);

`ifdef RESULT_WRITER_BYTE_MASK_EN
    // lane_q counts filled lanes while in S_WRITE, so every lane below it is live.
    always_comb begin
        bus.ram_byte_en = '0;
        if (state_q == S_WRITE) begin
            for (int i = 0; i < 4; i++) begin
                bus.ram_byte_en[i] = (3'(i) < lane_q);
            end
        end
    end
`endif
endmodule

// File: tb/tb_result_writer.sv
// Randomized bench for result_writer: three instances (2x2, 3x2, 4x2) share stimulus, sel picks one.
module tb_result_writer;
    logic        clk = 1'b0;
    logic        n_rst;
    int          sel;
    logic        tb_start, tb_pv, tb_ack;
    logic [31:0] tb_addr;
    logic [7:0]  tb_pin;

    logic            obs_ready, obs_write, obs_busy, obs_done;
    logic [31:0]     obs_addr;
    logic [31:0]     obs_wdata;
    logic [3:0]      obs_be;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] stim_pix[$];

    always #5 clk = ~clk;

    result_writer_if if_a ();
    result_writer_if if_b ();
    result_writer_if if_c ();

    assign if_a.start = tb_start && (sel == 0);
    assign if_b.start = tb_start && (sel == 1);
    assign if_c.start = tb_start && (sel == 2);
    assign if_a.start_addr = tb_addr;  assign if_b.start_addr = tb_addr;  assign if_c.start_addr = tb_addr;
    assign if_a.pixel_valid = tb_pv;   assign if_b.pixel_valid = tb_pv;   assign if_c.pixel_valid = tb_pv;
    assign if_a.pixel_in = tb_pin;     assign if_b.pixel_in = tb_pin;     assign if_c.pixel_in = tb_pin;
    assign if_a.ram_ack = tb_ack;      assign if_b.ram_ack = tb_ack;      assign if_c.ram_ack = tb_ack;

    result_writer #(.IMG_W(2), .IMG_H(2)) dut_a (.clk(clk), .n_rst(n_rst), .bus(if_a));
    result_writer #(.IMG_W(3), .IMG_H(2)) dut_b (.clk(clk), .n_rst(n_rst), .bus(if_b));
    result_writer #(.IMG_W(4), .IMG_H(2)) dut_c (.clk(clk), .n_rst(n_rst), .bus(if_c));

    always_comb begin
        obs_be = 4'hF;
        case (sel)
            1: begin
                obs_ready = if_b.pixel_ready; obs_write = if_b.ram_write; obs_busy = if_b.busy;
                obs_done = if_b.edge_write_done; obs_addr = if_b.ram_out_addr; obs_wdata = if_b.ram_wdata;
`ifdef RESULT_WRITER_BYTE_MASK_EN
                obs_be = if_b.ram_byte_en;
`endif
            end
            2: begin
                obs_ready = if_c.pixel_ready; obs_write = if_c.ram_write; obs_busy = if_c.busy;
                obs_done = if_c.edge_write_done; obs_addr = if_c.ram_out_addr; obs_wdata = if_c.ram_wdata;
`ifdef RESULT_WRITER_BYTE_MASK_EN
                obs_be = if_c.ram_byte_en;
`endif
            end
            default: begin
                obs_ready = if_a.pixel_ready; obs_write = if_a.ram_write; obs_busy = if_a.busy;
                obs_done = if_a.edge_write_done; obs_addr = if_a.ram_out_addr; obs_wdata = if_a.ram_wdata;
`ifdef RESULT_WRITER_BYTE_MASK_EN
                obs_be = if_a.ram_byte_en;
`endif
            end
        endcase
    end

    function automatic int npix_of(input int s);
        return (s == 1) ? 6 : (s == 2) ? 8 : 4;
    endfunction

    // One frame: drive stim_pix with random valid gaps and ack delays, check the RAM writes against
    // a word list computed directly from the pixel list and base address.
    task automatic run_frame(input int s, input logic [31:0] base, input int pv_pct,
                             input int ack_min, input int ack_max, input bit noisy, input string tag);
        logic [31:0] exp_addr[$], exp_data[$], got_addr[$], got_data[$];
        logic [3:0]  exp_be[$], got_be[$];
        logic [31:0] cap_addr, cap_data, a, d;
        logic [3:0]  cap_be, be;
        int npix, nw, sent, done_cnt, after_done, wait_c, cyc;
        bit pend, word_due;
        npix = npix_of(s);
        nw = (npix + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            a = (base & 32'hFFFF_FFFC) + 32'(4 * w);
            d = '0;
            be = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * w + l < npix) begin
                    d[8*l +: 8] = stim_pix[4*w + l];
                    be[l] = 1'b1;
                end
            end
            exp_addr.push_back(a); exp_data.push_back(d); exp_be.push_back(be);
        end
        sel = s; tb_addr = base; tb_pv = 0; tb_ack = 0;
        sent = 0; done_cnt = 0; after_done = 0; wait_c = 0; cyc = 0; pend = 0; word_due = 0;
        cap_addr = '0; cap_data = '0; cap_be = '0;
        @(negedge clk); tb_start = 1;
        @(negedge clk); tb_start = 0;
        vectors++;
        if (obs_busy !== 1'b1) begin
            miscompares++; $display("FAIL %s busy_after_start: got %b exp 1", tag, obs_busy);
        end
        while (cyc < 400 && after_done < 3) begin
            if (word_due) begin
                vectors++;
                if (obs_write !== 1'b1) begin
                    miscompares++; $display("FAIL %s write_latency: ram_write %b exp 1", tag, obs_write);
                end
                word_due = 0;
            end
            if (obs_write === 1'b1 && obs_ready !== 1'b0) begin
                vectors++; miscompares++;
                $display("FAIL %s ready_in_write: pixel_ready %b exp 0", tag, obs_ready);
            end
            if (obs_write === 1'b1) begin
                if (!pend) begin
                    pend = 1; cap_addr = obs_addr; cap_data = obs_wdata; cap_be = obs_be;
                    wait_c = $urandom_range(ack_max, ack_min);
                end else begin
                    vectors++;
                    if (obs_addr !== cap_addr || obs_wdata !== cap_data || obs_be !== cap_be) begin
                        miscompares++;
                        $display("FAIL %s hold_stable: got %h/%h/%b exp %h/%h/%b", tag,
                                 obs_addr, obs_wdata, obs_be, cap_addr, cap_data, cap_be);
                    end
                end
            end
            if (obs_done === 1'b1) done_cnt++;
            if (done_cnt > 0) after_done++;
            tb_ack = 0;
            if (pend) begin
                if (wait_c == 0) begin
                    tb_ack = 1; pend = 0;
                    got_addr.push_back(cap_addr); got_data.push_back(cap_data); got_be.push_back(cap_be);
                end else begin
                    wait_c--;
                end
            end else if (noisy) begin
                tb_ack = 1'($urandom_range(1, 0));
            end
            tb_pv = 0;
            if (obs_ready === 1'b1) begin
                if (sent < npix && int'($urandom % 100) < pv_pct) begin
                    tb_pv = 1; tb_pin = stim_pix[sent]; sent++;
                    if (sent % 4 == 0 || sent == npix) word_due = 1;
                end
            end else if (noisy) begin
                tb_pv = 1; tb_pin = 8'($urandom);
            end
            tb_start = noisy && (obs_busy === 1'b1) && ($urandom_range(3, 0) == 0);
            @(negedge clk);
            cyc++;
        end
        tb_pv = 0; tb_ack = 0; tb_start = 0;
        vectors++;
        if (done_cnt != 1) begin
            miscompares++; $display("FAIL %s done_pulse: got %0d cycles exp 1", tag, done_cnt);
        end
        vectors++;
        if (obs_busy !== 1'b0) begin
            miscompares++; $display("FAIL %s busy_end: got %b exp 0", tag, obs_busy);
        end
        vectors++;
        if (got_addr.size() != nw) begin
            miscompares++; $display("FAIL %s word_count: got %0d exp %0d", tag, got_addr.size(), nw);
        end
        for (int w = 0; w < nw && w < got_addr.size(); w++) begin
            vectors++;
            if (got_addr[w] !== exp_addr[w] || got_data[w] !== exp_data[w]) begin
                miscompares++;
                $display("FAIL %s word%0d: got %h:%h exp %h:%h", tag, w,
                         got_addr[w], got_data[w], exp_addr[w], exp_data[w]);
            end
`ifdef RESULT_WRITER_BYTE_MASK_EN
            vectors++;
            if (got_be[w] !== exp_be[w]) begin
                miscompares++; $display("FAIL %s byte_en%0d: got %b exp %b", tag, w, got_be[w], exp_be[w]);
            end
`endif
        end
    endtask

    task automatic fill_random(input int n);
        stim_pix.delete();
        for (int i = 0; i < n; i++) stim_pix.push_back(8'($urandom));
    endtask

    task automatic fill_basic();
        stim_pix.delete();
        stim_pix.push_back(8'd10); stim_pix.push_back(8'd11);
        stim_pix.push_back(8'd255); stim_pix.push_back(8'd254);
    endtask

    task automatic test_reset();
        int cyc;
        #1;
        vectors++;
        if ({obs_ready, obs_write, obs_busy, obs_done} !== 4'b0 || obs_addr !== 32'h0 || obs_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_values: flags %b addr %h data %h exp all 0",
                     {obs_ready, obs_write, obs_busy, obs_done}, obs_addr, obs_wdata);
        end
        @(negedge clk); n_rst = 1;
        sel = 0; tb_addr = 32'h0000_1230; fill_random(4);
        @(negedge clk); tb_start = 1;
        @(negedge clk); tb_start = 0;
        for (int i = 0; i < 4; i++) begin
            tb_pv = 1; tb_pin = stim_pix[i];
            @(negedge clk);
        end
        tb_pv = 0;
        vectors++;
        if (obs_write !== 1'b1) begin
            miscompares++; $display("FAIL reset_reach_write: ram_write %b exp 1", obs_write);
        end
        #2 n_rst = 0;
        #1;
        vectors++;
        if ({obs_ready, obs_write, obs_busy, obs_done} !== 4'b0 || obs_addr !== 32'h0 || obs_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_async: flags %b addr %h data %h exp all 0",
                     {obs_ready, obs_write, obs_busy, obs_done}, obs_addr, obs_wdata);
        end
        @(negedge clk); n_rst = 1;
        for (cyc = 0; cyc < 12; cyc++) begin
            tb_pv = 1; tb_pin = 8'($urandom); tb_ack = 1'(cyc % 2);
            @(negedge clk);
            vectors++;
            if (obs_write !== 1'b0 || obs_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_write: write %b busy %b exp 0 0", obs_write, obs_busy);
            end
        end
        tb_pv = 0; tb_ack = 0;
    endtask

    task automatic test_basic();
        fill_basic();
        run_frame(0, 32'd100, 100, 1, 1, 1'b0, "basic");
    endtask

    task automatic test_backpressure();
        fill_random(8);
        run_frame(2, 32'h0000_4000, 100, 5, 5, 1'b0, "backpressure");
    endtask

    task automatic test_partial();
        fill_random(6);
        run_frame(1, 32'h0000_0103, 100, 0, 3, 1'b0, "partial");
    endtask

    task automatic test_ignore();
        fill_basic();
        run_frame(0, 32'd100, 50, 0, 3, 1'b1, "ignore");
    endtask

    task automatic test_wrap();
        fill_random(8);
        run_frame(2, 32'hFFFF_FFFC, 100, 0, 2, 1'b0, "wrap");
    endtask

    task automatic test_back_to_back();
        int s;
        for (int k = 0; k < 8; k++) begin
            s = $urandom_range(2, 0);
            fill_random(npix_of(s));
            run_frame(s, $urandom, $urandom_range(100, 30), 0, 4, 1'($urandom_range(1, 0)), "random");
        end
    endtask

    initial begin
        n_rst = 0; sel = 0; tb_start = 0; tb_pv = 0; tb_ack = 0; tb_addr = '0; tb_pin = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_partial();
        test_ignore();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
